// File: rtl/ddr2_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ddr2_port_arbiter_if
//  Purpose  : Bundles the two requester ports and the DDR2 controller client
//             port that ddr2_port_arbiter sits between.
//  Ports    : p0_*/p1_*  requester address, write data, rd/wr levels, rdata, ack
//             c_*        controller address/data, rd/wr requests, rdy, ack
//             busy/err/err_port  arbiter status
//  Modports : master = arbiter side, slave = requesters + controller side
//  Revision : 1.0  initial release
// ============================================================================
interface ddr2_port_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_rd;
  logic              p1_rd;
  logic              p0_wr;
  logic              p1_wr;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p0_ack;
  logic              p1_ack;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data_in;
  logic [DATA_W-1:0] c_data_out;
  logic              c_rdy;
  logic              c_ack;
  logic              c_rd_req;
  logic              c_wr_req;
  logic              busy;
  logic              err;
  logic              err_port;

  modport master (
    input  p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rd, p1_rd, p0_wr, p1_wr,
    input  c_data_out, c_rdy, c_ack,
    output p0_rdata, p1_rdata, p0_ack, p1_ack,
    output c_addr, c_data_in, c_rd_req, c_wr_req,
    output busy, err, err_port
  );

  modport slave (
    output p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rd, p1_rd, p0_wr, p1_wr,
    output c_data_out, c_rdy, c_ack,
    input  p0_rdata, p1_rdata, p0_ack, p1_ack,
    input  c_addr, c_data_in, c_rd_req, c_wr_req,
    input  busy, err, err_port
  );
endinterface
`default_nettype wire

// File: rtl/ddr2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr2_port_arbiter
//  Purpose  : Round-robin arbiter sharing the DDR2 controller client port
//             between two requesters, one 64-bit read or write at a time,
//             with a watchdog that aborts unacknowledged transactions.
//  Ports    : clk  controller clock (rising edge)
//             rst  synchronous active-high reset
//             bus  ddr2_port_arbiter_if.master (requesters + controller)
//  Revision : 1.0  initial release
// ============================================================================
module ddr2_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  wire logic           clk,
  input  wire logic           rst,
  ddr2_port_arbiter_if.master bus
);
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            r_state,    w_state;
  logic              r_owner,    w_owner;
  logic              r_last,     w_last;
  logic              r_is_rd,    w_is_rd;
  logic [ADDR_W-1:0] r_addr,     w_addr;
  logic [DATA_W-1:0] r_wdata,    w_wdata;
  logic [DATA_W-1:0] r_rdata0,   w_rdata0;
  logic [DATA_W-1:0] r_rdata1,   w_rdata1;
  logic [15:0]       r_wd,       w_wd;
  logic              r_rd_req,   w_rd_req;
  logic              r_wr_req,   w_wr_req;
  logic              r_ack0,     w_ack0;
  logic              r_ack1,     w_ack1;
  logic              r_busy,     w_busy;
  logic              r_err,      w_err;
  logic              r_err_port, w_err_port;

  logic w_pend0, w_pend1, w_win, w_win_rd;

  // A port whose rd and wr are both high is served as a read.
  assign w_pend0  = bus.p0_rd | bus.p0_wr;
  assign w_pend1  = bus.p1_rd | bus.p1_wr;
  assign w_win    = (w_pend0 & w_pend1) ? ~r_last : w_pend1;
  assign w_win_rd = w_win ? bus.p1_rd : bus.p0_rd;

  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_last     = r_last;
    w_is_rd    = r_is_rd;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_rdata0   = r_rdata0;
    w_rdata1   = r_rdata1;
    w_wd       = r_wd;
    w_rd_req   = r_rd_req;
    w_wr_req   = r_wr_req;
    w_ack0     = 1'b0;
    w_ack1     = 1'b0;
    w_err      = 1'b0;
    w_err_port = r_err_port;

    case (r_state)
      S_IDLE: begin
        if (bus.c_rdy && (w_pend0 || w_pend1)) begin
          w_state  = S_BUSY;
          w_owner  = w_win;
          w_addr   = w_win ? bus.p1_addr  : bus.p0_addr;
          w_wdata  = w_win ? bus.p1_wdata : bus.p0_wdata;
          w_is_rd  = w_win_rd;
          w_wd     = 16'd0;
          w_rd_req = w_win_rd;
          w_wr_req = ~w_win_rd;
        end
      end
      S_BUSY: begin
        // An ack landing in the watchdog's final cycle still completes.
        if (bus.c_ack) begin
          if (r_owner) begin
            w_rdata1 = bus.c_data_out;
            w_ack1   = 1'b1;
          end else begin
            w_rdata0 = bus.c_data_out;
            w_ack0   = 1'b1;
          end
          w_last   = r_owner;
          w_rd_req = 1'b0;
          w_wr_req = 1'b0;
          w_state  = S_RELEASE;
        end else if (r_wd == c_TIMEOUT) begin
          w_rd_req   = 1'b0;
          w_wr_req   = 1'b0;
          w_err      = 1'b1;
          w_err_port = r_owner;
          w_last     = r_owner;
          w_state    = S_RELEASE;
        end else begin
          w_wd = r_wd + 16'd1;
        end
      end
      S_RELEASE: begin
        // Controller raises c_rdy again once its precharge is done.
        if (bus.c_rdy) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_is_rd    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_wd       <= 16'd0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_err_port <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_owner    <= w_owner;
      r_last     <= w_last;
      r_is_rd    <= w_is_rd;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_rdata0   <= w_rdata0;
      r_rdata1   <= w_rdata1;
      r_wd       <= w_wd;
      r_rd_req   <= w_rd_req;
      r_wr_req   <= w_wr_req;
      r_ack0     <= w_ack0;
      r_ack1     <= w_ack1;
      r_busy     <= w_busy;
      r_err      <= w_err;
      r_err_port <= w_err_port;
    end
  end

  assign bus.c_addr    = r_addr;
  assign bus.c_data_in = r_wdata;
  assign bus.c_rd_req  = r_rd_req;
  assign bus.c_wr_req  = r_wr_req;
  assign bus.p0_rdata  = r_rdata0;
  assign bus.p1_rdata  = r_rdata1;
  assign bus.p0_ack    = r_ack0;
  assign bus.p1_ack    = r_ack1;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
  assign bus.err_port  = r_err_port;
endmodule
`default_nettype wire

// File: tb/tb_ddr2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr2_port_arbiter
//  Purpose  : Self-checking bench for ddr2_port_arbiter: directed scenarios
//             plus randomized requester/controller traffic checked every
//             cycle against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr2_port_arbiter;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 64;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr2_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr2_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model (transaction level) ----------------
  int          cyc = 0;
  bit          m_txn, m_drain, m_own, m_last, m_rd;
  logic [25:0] m_addr;
  logic [63:0] m_wdata;
  int          m_start;
  bit          e_rd_req, e_wr_req, e_ack0, e_ack1, e_err, e_err_port, e_busy;
  logic [63:0] e_rdata0, e_rdata1;

  // ---------------- stimulus agents ----------------
  int          ctl_st = 0;
  int          ctl_cnt = 0;
  int          ctl_fix_lat = -1;
  bit          ctl_noack = 0;
  bit          ctl_use_fixed = 0;
  logic [63:0] ctl_fixed = '0;
  bit          stray = 0;
  bit          rand_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advances the model across one rising edge using the inputs the DUT samples.
  task automatic model_update();
    bit p0, p1, pick;
    cyc++;
    e_ack0 = 0; e_ack1 = 0; e_err = 0;
    p0 = bus.p0_rd | bus.p0_wr;
    p1 = bus.p1_rd | bus.p1_wr;
    if (rst) begin
      m_txn = 0; m_drain = 0; m_own = 0; m_last = 1; m_rd = 0;
      m_addr = '0; m_wdata = '0; e_rdata0 = '0; e_rdata1 = '0; e_err_port = 0;
    end else if (m_txn) begin
      if (bus.c_ack) begin
        if (m_own) begin e_ack1 = 1; e_rdata1 = bus.c_data_out; end
        else       begin e_ack0 = 1; e_rdata0 = bus.c_data_out; end
        m_last = m_own; m_txn = 0; m_drain = 1;
      end else if (cyc - m_start == TO + 1) begin
        e_err = 1; e_err_port = m_own; m_last = m_own; m_txn = 0; m_drain = 1;
      end
    end else if (m_drain) begin
      if (bus.c_rdy) m_drain = 0;
    end else if (bus.c_rdy && (p0 || p1)) begin
      pick    = (p0 && p1) ? !m_last : p1;
      m_own   = pick;
      m_rd    = pick ? bus.p1_rd : bus.p0_rd;
      m_addr  = pick ? bus.p1_addr : bus.p0_addr;
      m_wdata = pick ? bus.p1_wdata : bus.p0_wdata;
      m_txn   = 1;
      m_start = cyc;
    end
    e_rd_req = m_txn & m_rd;
    e_wr_req = m_txn & !m_rd;
    e_busy   = m_txn | m_drain;
  endtask

  task automatic compare();
    chk("c_rd_req",  bus.c_rd_req,  e_rd_req);
    chk("c_wr_req",  bus.c_wr_req,  e_wr_req);
    chk("c_addr",    bus.c_addr,    m_addr);
    chk("c_data_in", bus.c_data_in, m_wdata);
    chk("p0_ack",    bus.p0_ack,    e_ack0);
    chk("p1_ack",    bus.p1_ack,    e_ack1);
    chk("p0_rdata",  bus.p0_rdata,  e_rdata0);
    chk("p1_rdata",  bus.p1_rdata,  e_rdata1);
    chk("busy",      bus.busy,      e_busy);
    chk("err",       bus.err,       e_err);
    chk("err_port",  bus.err_port,  e_err_port);
  endtask

  task automatic agents();
    bit req;
    // Requesters drop their request in the ack cycle.
    if (bus.p0_ack) begin bus.p0_rd = 0; bus.p0_wr = 0; end
    if (bus.p1_ack) begin bus.p1_rd = 0; bus.p1_wr = 0; end
    if (rand_en) begin
      if (!(bus.p0_rd | bus.p0_wr) && !bus.p0_ack && ($urandom % 4 == 0)) begin
        bus.p0_addr = 26'($urandom); bus.p0_wdata = {$urandom, $urandom};
        case ($urandom % 3) 0: bus.p0_rd = 1; 1: bus.p0_wr = 1; default: begin bus.p0_rd = 1; bus.p0_wr = 1; end endcase
      end
      if (!(bus.p1_rd | bus.p1_wr) && !bus.p1_ack && ($urandom % 4 == 0)) begin
        bus.p1_addr = 26'($urandom); bus.p1_wdata = {$urandom, $urandom};
        case ($urandom % 3) 0: bus.p1_rd = 1; 1: bus.p1_wr = 1; default: begin bus.p1_rd = 1; bus.p1_wr = 1; end endcase
      end
    end
    // Controller: idle with rdy high, ack after a latency, then precharge.
    req = bus.c_rd_req | bus.c_wr_req;
    bus.c_ack = 0;
    case (ctl_st)
      0: begin
        bus.c_rdy = 1;
        if (req) begin
          ctl_st = 1; bus.c_rdy = 0;
          ctl_cnt = (ctl_fix_lat >= 0) ? ctl_fix_lat : int'($urandom_range(0, 6));
        end
      end
      1: begin
        if (!req) begin ctl_st = 2; ctl_cnt = int'($urandom_range(0, 3)); end
        else if (ctl_cnt == 0) begin
          if (!ctl_noack) begin
            bus.c_ack = 1;
            bus.c_data_out = ctl_use_fixed ? ctl_fixed : {$urandom, $urandom};
          end
        end else ctl_cnt--;
      end
      default: begin
        if (ctl_cnt == 0) begin bus.c_rdy = 1; ctl_st = 0; end
        else ctl_cnt--;
      end
    endcase
    if (stray) begin bus.c_ack = 1; stray = 0; end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare();
    agents();
  endtask

  task automatic do_reset();
    rst = 1; step(); step();
    rst = 0; step();
  endtask

  initial begin
    int got, n0, n1, k, a0, a1;
    bit prev_req;
    int order[$];

    bus.p0_addr = '0; bus.p1_addr = '0; bus.p0_wdata = '0; bus.p1_wdata = '0;
    bus.p0_rd = 0; bus.p1_rd = 0; bus.p0_wr = 0; bus.p1_wr = 0;
    bus.c_data_out = '0; bus.c_rdy = 1; bus.c_ack = 0;

    // Reset state.
    rst = 1; step(); step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_req", bus.c_rd_req, 0);
    chk("rst_addr", bus.c_addr, 0);
    rst = 0; step();

    // T1: single read from port 0 with a known controller response.
    ctl_use_fixed = 1; ctl_fixed = 64'hDEADBEEF_CAFEF00D; ctl_fix_lat = 3;
    bus.p0_addr = 26'h0123456; bus.p0_rd = 1;
    step();
    chk("t1_rd_req_after_grant", bus.c_rd_req, 1);
    chk("t1_c_addr", bus.c_addr, 26'h0123456);
    got = 0; n1 = 0;
    for (int i = 0; i < 30 && got == 0; i++) begin
      step();
      if (bus.p1_ack) n1++;
      if (bus.p0_ack) begin
        got = 1;
        chk("t1_p0_rdata", bus.p0_rdata, 64'hDEADBEEF_CAFEF00D);
      end
    end
    chk("t1_p0_ack_seen", got, 1);
    n0 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.p0_ack) n0++;
      if (bus.p1_ack) n1++;
    end
    chk("t1_p0_ack_single_pulse", n0, 0);
    chk("t1_p1_ack_quiet", n1, 0);
    ctl_use_fixed = 0; ctl_fix_lat = -1;

    // T2: both ports contend after reset; grant order must alternate from port 0.
    do_reset();
    bus.p0_addr = 26'h0000100; bus.p0_wdata = 64'h1111_2222_3333_4444; bus.p0_wr = 1;
    bus.p1_addr = 26'h0000200; bus.p1_rd = 1;
    a0 = 0; a1 = 0; prev_req = 0;
    for (int i = 0; i < 400 && (a0 < 4 || a1 < 4); i++) begin
      step();
      if ((bus.c_rd_req | bus.c_wr_req) && !prev_req) begin
        if (order.size() == 0) begin
          chk("t2_first_wr_req", bus.c_wr_req, 1);
          chk("t2_first_data_in", bus.c_data_in, 64'h1111_2222_3333_4444);
        end
        order.push_back(bus.c_wr_req ? 0 : 1);
      end
      prev_req = bus.c_rd_req | bus.c_wr_req;
      if (bus.p0_ack) a0++; else if (!bus.p0_wr && a0 < 4) bus.p0_wr = 1;
      if (bus.p1_ack) a1++; else if (!bus.p1_rd && a1 < 4) bus.p1_rd = 1;
    end
    chk("t2_grant_count", order.size(), 8);
    for (int i = 0; i < order.size(); i++) chk($sformatf("t2_grant_%0d", i), order[i], i % 2);

    // T3: rd and wr together on port 1 are served as a read only.
    bus.p1_addr = 26'h3FFFFFF; bus.p1_rd = 1; bus.p1_wr = 1;
    got = 0; n0 = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      chk("t3_no_wr_req", bus.c_wr_req, 0);
      if (bus.c_rd_req) n0++;
      if (bus.p1_ack) got = 1;
    end
    chk("t3_p1_ack_seen", got, 1);
    chk("t3_rd_req_seen", n0 > 0, 1);
    for (int i = 0; i < 6; i++) step();

    // T4: controller never acks -> watchdog abort, then normal service.
    ctl_noack = 1;
    bus.p1_addr = 26'h0ABCDEF; bus.p1_rd = 1;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      step();
      if (bus.c_rd_req) got = 1;
    end
    chk("t4_rd_req_rise", got, 1);
    k = 0; got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step(); k++;
      if (bus.err) begin
        got = 1;
        chk("t4_err_port", bus.err_port, 1);
        chk("t4_rd_req_dropped", bus.c_rd_req, 0);
        chk("t4_no_ack", bus.p1_ack, 0);
      end
    end
    chk("t4_err_delay", k, 17);
    ctl_noack = 0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (bus.p1_ack) got = 1;
    end
    chk("t4_served_after_abort", got, 1);
    chk("t4_err_port_held", bus.err_port, 1);

    // T5: leave last=0 via a port-0 op, then reset mid-transaction.
    bus.p0_addr = 26'h0000010; bus.p0_wdata = 64'h5; bus.p0_wr = 1;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin step(); if (bus.p0_ack) got = 1; end
    chk("t5_prep_ack", got, 1);
    for (int i = 0; i < 6; i++) step();
    ctl_fix_lat = 10;
    bus.p0_addr = 26'h0000020; bus.p0_rd = 1;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin step(); if (bus.c_rd_req) got = 1; end
    chk("t5_busy_before_rst", got, 1);
    step(); step();
    rst = 1; step();
    chk("t5_rd_req_after_rst", bus.c_rd_req, 0);
    chk("t5_busy_after_rst", bus.busy, 0);
    chk("t5_no_ack_after_rst", bus.p0_ack, 0);
    rst = 0; bus.p0_rd = 0; ctl_fix_lat = -1;
    step();
    stray = 1;
    n0 = 0;
    for (int i = 0; i < 6; i++) begin step(); if (bus.p0_ack | bus.p1_ack) n0++; end
    chk("t5_stray_ack_ignored", n0, 0);
    bus.p0_addr = 26'h0000AAA; bus.p0_rd = 1;
    bus.p1_addr = 26'h0000BBB; bus.p1_wr = 1;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      step();
      if (bus.c_rd_req | bus.c_wr_req) begin
        got = 1;
        chk("t5_p0_priority", bus.c_rd_req, 1);
        chk("t5_p0_addr", bus.c_addr, 26'h0000AAA);
      end
    end
    chk("t5_grant_seen", got, 1);
    for (int i = 0; i < 100 && (bus.p0_rd | bus.p1_wr); i++) step();
    chk("t5_drained", bus.p0_rd | bus.p1_wr, 0);

    // Randomized traffic checked against the model every cycle.
    rand_en = 1;
    for (int i = 0; i < 1500; i++) step();
    rand_en = 0;
    for (int i = 0; i < 150 && (bus.p0_rd | bus.p0_wr | bus.p1_rd | bus.p1_wr); i++) step();
    chk("rand_drained", bus.p0_rd | bus.p0_wr | bus.p1_rd | bus.p1_wr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
